// File: rtl/aig_sweep_pkg.sv
// Shared types, default constants and the MISR update rule for the AIG sweep collector.
package aig_sweep_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam int unsigned DEF_SIG_W    = 16;
  localparam logic [15:0] DEF_SIG_POLY = 16'h1021;
  localparam logic [15:0] DEF_SIG_SEED = 16'hFFFF;
  localparam int unsigned MISR_MAX_W   = 64;

  // Width-generic MISR step; operands are zero-extended into MISR_MAX_W bits, result masked to w bits.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] data,
    input logic [MISR_MAX_W-1:0] poly,
    input int unsigned           w
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] fb;
    mask = (MISR_MAX_W'(1) << w) - MISR_MAX_W'(1);
    fb   = (((sig >> (w - 1)) & MISR_MAX_W'(1)) != '0) ? poly : '0;
    return ((sig << 1) ^ fb ^ data) & mask;
  endfunction

endpackage

// File: rtl/aig_sweep_misr.sv
// Signature register: loads the seed on request and folds one data word per enabled cycle.
module aig_sweep_misr
  import aig_sweep_pkg::*;
#(
  parameter int unsigned      SIG_W    = DEF_SIG_W,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEF_SIG_POLY),
  parameter logic [SIG_W-1:0] SIG_SEED = SIG_W'(DEF_SIG_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [SIG_W-1:0] data,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_next;

  always_comb begin
    w_next = SIG_W'(misr_next(MISR_MAX_W'(r_sig), MISR_MAX_W'(data),
                              MISR_MAX_W'(SIG_POLY), SIG_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= SIG_SEED;
    end else if (load) begin
      r_sig <= SIG_SEED;
    end else if (en) begin
      r_sig <= w_next;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/aig_sweep_collector.sv
// Exhaustive input sweep + MISR response compaction for small AIG netlists.
// Optional response capture RAM enabled by defining AIG_SWEEP_CAPTURE_EN.
module aig_sweep_collector
  import aig_sweep_pkg::*;
#(
  parameter int unsigned      N_IN          = 5,
  parameter int unsigned      N_OUT         = 10,
  parameter int unsigned      SIG_W         = DEF_SIG_W,
  parameter logic [SIG_W-1:0] SIG_POLY      = SIG_W'(DEF_SIG_POLY),
  parameter logic [SIG_W-1:0] SIG_SEED      = SIG_W'(DEF_SIG_SEED),
  parameter int unsigned      SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   x_out,
  input  logic [N_OUT-1:0]  f_in,
  input  logic [SIG_W-1:0]  expected_sig,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature
`ifdef AIG_SWEEP_CAPTURE_EN
  ,
  input  logic [N_IN-1:0]   rd_addr,
  output logic [N_OUT-1:0]  rd_data
`endif
);

  localparam int unsigned     SET_W      = 4;
  localparam logic [N_IN-1:0] VEC_LAST   = '1;
  localparam logic [SET_W-1:0] SET_RELOAD = SET_W'(SETTLE_CYCLES);

  state_t           r_state, w_state_nxt;
  logic [N_IN-1:0]  r_vec, w_vec_nxt;
  logic [SET_W-1:0] r_set, w_set_nxt;
  logic             r_busy, r_done, r_pass;
  logic             w_pass_nxt;
  logic             w_misr_load, w_misr_en;
  logic [SIG_W-1:0] w_sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_vec   <= '0;
      r_set   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_set   <= w_set_nxt;
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= (w_state_nxt == FINISH);
      r_pass  <= w_pass_nxt;
    end
  end

  // Next state and register updates; abort always takes priority over start or sampling.
  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_set_nxt   = r_set;
    w_pass_nxt  = r_pass;
    w_misr_load = 1'b0;
    w_misr_en   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_state_nxt = RUN;
          w_vec_nxt   = '0;
          w_set_nxt   = SET_RELOAD;
          w_pass_nxt  = 1'b0;
          w_misr_load = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_vec_nxt   = '0;
          w_set_nxt   = '0;
          w_pass_nxt  = 1'b0;
        end else if (r_set == '0) begin
          w_misr_en = 1'b1;
          w_set_nxt = SET_RELOAD;
          if (r_vec == VEC_LAST) begin
            w_state_nxt = FINISH;
            w_vec_nxt   = '0;
          end else begin
            w_vec_nxt = r_vec + N_IN'(1);
          end
        end else begin
          w_set_nxt = r_set - SET_W'(1);
        end
      end
      FINISH: begin
        w_state_nxt = IDLE;
        w_set_nxt   = '0;
        w_pass_nxt  = abort ? 1'b0 : (w_sig == expected_sig);
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  aig_sweep_misr #(
    .SIG_W    (SIG_W),
    .SIG_POLY (SIG_POLY),
    .SIG_SEED (SIG_SEED)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_misr_load),
    .en    (w_misr_en),
    .data  (SIG_W'(f_in)),
    .sig   (w_sig)
  );

`ifdef AIG_SWEEP_CAPTURE_EN
  localparam int unsigned N_VEC = 1 << N_IN;

  logic [N_OUT-1:0] r_mem [N_VEC];
  logic [N_OUT-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (w_misr_en) begin
      r_mem[r_vec] <= f_in;
    end
  end

  // Same-address read during a write returns the previous contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;
`endif

  assign x_out     = r_vec;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = w_sig;

endmodule

// File: tb/tb_aig_sweep_collector.sv
// Directed bench for aig_sweep_collector: default, zero-seed and zero-settle instances.
module tb_aig_sweep_collector;
  import aig_sweep_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic        start_a, abort_a, busy_a, done_a, pass_a;
  logic [4:0]  x_a;
  logic [9:0]  f_a;
  logic [15:0] exp_a, sig_a;

  logic        start_b, abort_b, busy_b, done_b, pass_b;
  logic [4:0]  x_b;
  logic [9:0]  f_b;
  logic [15:0] exp_b, sig_b;

  logic        start_c, abort_c, busy_c, done_c, pass_c;
  logic [4:0]  x_c;
  logic [9:0]  f_c;
  logic [15:0] exp_c, sig_c;

`ifdef AIG_SWEEP_CAPTURE_EN
  logic [4:0] rd_addr_a, rd_addr_b, rd_addr_c;
  logic [9:0] rd_data_a, rd_data_b, rd_data_c;
`endif

  assign f_a = 10'(x_a);
  assign f_b = 10'd0;
  assign f_c = 10'(x_c);

  aig_sweep_collector dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .x_out(x_a),
    .f_in(f_a), .expected_sig(exp_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a)
`ifdef AIG_SWEEP_CAPTURE_EN
    , .rd_addr(rd_addr_a), .rd_data(rd_data_a)
`endif
  );

  aig_sweep_collector #(.SIG_SEED(16'h0000)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .x_out(x_b),
    .f_in(f_b), .expected_sig(exp_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b)
`ifdef AIG_SWEEP_CAPTURE_EN
    , .rd_addr(rd_addr_b), .rd_data(rd_data_b)
`endif
  );

  aig_sweep_collector #(.SETTLE_CYCLES(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c), .x_out(x_c),
    .f_in(f_c), .expected_sig(exp_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .signature(sig_c)
`ifdef AIG_SWEEP_CAPTURE_EN
    , .rd_addr(rd_addr_c), .rd_data(rd_data_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected signature after the first n loopback vectors (data == vector index).
  function automatic logic [15:0] model(input int n);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int v = 0; v < n; v++) begin
      s = 16'(misr_next(64'(s), 64'(v), 64'(16'h1021), 16));
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_a); end
    total++; if (pass_a !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b exp=0", pass_a); end
    total++; if (x_a !== 5'd0) begin bad++; $display("FAIL reset_x got=%h exp=00", x_a); end
    total++; if (sig_a !== 16'hFFFF) begin bad++; $display("FAIL reset_sig got=%h exp=ffff", sig_a); end
    total++; if (sig_b !== 16'h0000) begin bad++; $display("FAIL reset_sig_b got=%h exp=0000", sig_b); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_timing();
    int          first_busy = -1;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    int          done_idx = -1;
    logic [15:0] sigv = 16'hFFFF;
    logic        passv = 1'b0;
    exp_b = 16'h0000;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      if (busy_b) begin busy_cnt++; if (first_busy < 0) first_busy = i; end
      if (done_b) begin done_cnt++; done_idx = i; end
      if (i == 65) sigv = sig_b;
      if (i == 66) passv = pass_b;
      tick();
    end
    total++; if (first_busy != 1) begin bad++; $display("FAIL timing_first_busy got=%0d exp=1", first_busy); end
    total++; if (busy_cnt != 64) begin bad++; $display("FAIL timing_busy_cnt got=%0d exp=64", busy_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL timing_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (done_idx != 65) begin bad++; $display("FAIL timing_done_idx got=%0d exp=65", done_idx); end
    total++; if (sigv !== 16'h0000) begin bad++; $display("FAIL timing_sig got=%h exp=0000", sigv); end
    total++; if (passv !== 1'b1) begin bad++; $display("FAIL timing_pass got=%b exp=1", passv); end
  endtask

  task automatic test_loopback();
    for (int k = 0; k < 2; k++) begin
      int          xerr = 0;
      int          done_idx = -1;
      logic [15:0] sigv = 16'h0000;
      logic        passv = 1'b0;
      exp_a = (k == 0) ? model(32) : (model(32) ^ 16'h0001);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int i = 1; i <= 70; i++) begin
        if (i <= 64 && x_a !== 5'((i - 1) / 2)) xerr++;
        if (i > 64 && x_a !== 5'd0) xerr++;
        if (done_a) begin done_idx = i; sigv = sig_a; end
        if (i == 66) passv = pass_a;
        tick();
      end
      total++; if (xerr != 0) begin bad++; $display("FAIL loop%0d_x_seq got=%0d_errors exp=0", k, xerr); end
      total++; if (done_idx != 65) begin bad++; $display("FAIL loop%0d_done_idx got=%0d exp=65", k, done_idx); end
      total++; if (sigv !== model(32)) begin bad++; $display("FAIL loop%0d_sig got=%h exp=%h", k, sigv, model(32)); end
      total++; if (passv !== (k == 0)) begin bad++; $display("FAIL loop%0d_pass got=%b exp=%b", k, passv, k == 0); end
    end
  endtask

  task automatic test_start_ignored();
    int done_cnt = 0;
    int done_idx = -1;
    exp_a = model(32);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      start_a = (i == 10 || i == 40 || i == 65);
      if (done_a) begin done_cnt++; done_idx = i; end
      tick();
    end
    start_a = 1'b0;
    total++; if (done_idx != 65) begin bad++; $display("FAIL busy_start_done_idx got=%0d exp=65", done_idx); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL busy_start_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (sig_a !== model(32)) begin bad++; $display("FAIL busy_start_sig got=%h exp=%h", sig_a, model(32)); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL busy_start_idle got=%b exp=0", busy_a); end
  endtask

  task automatic test_abort();
    int done_cnt = 0;
    int done_idx = -1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done_a); end
    total++; if (pass_a !== 1'b0) begin bad++; $display("FAIL abort_pass got=%b exp=0", pass_a); end
    total++; if (sig_a !== model(9)) begin bad++; $display("FAIL abort_sig got=%h exp=%h", sig_a, model(9)); end
    for (int i = 0; i < 70; i++) begin
      if (done_a || busy_a) done_cnt++;
      tick();
    end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
    // abort together with start in IDLE drops the start
    start_a = 1'b1;
    abort_a = 1'b1;
    tick();
    start_a = 1'b0;
    abort_a = 1'b0;
    tick();
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL abort_start_busy got=%b exp=0", busy_a); end
    exp_a = model(32);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    done_cnt = 0;
    for (int i = 1; i <= 70; i++) begin
      if (done_a) begin done_cnt++; done_idx = i; end
      tick();
    end
    total++; if (done_idx != 65) begin bad++; $display("FAIL abort_rerun_done got=%0d exp=65", done_idx); end
    total++; if (sig_a !== model(32)) begin bad++; $display("FAIL abort_rerun_sig got=%h exp=%h", sig_a, model(32)); end
    total++; if (pass_a !== 1'b1) begin bad++; $display("FAIL abort_rerun_pass got=%b exp=1", pass_a); end
  endtask

  task automatic test_settle0();
    int xerr = 0;
    int busy_cnt = 0;
    int done_idx = -1;
    logic [15:0] sigv = 16'h0000;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i <= 32 && x_c !== 5'(i - 1)) xerr++;
      if (busy_c) busy_cnt++;
      if (done_c) begin done_idx = i; sigv = sig_c; end
      tick();
    end
    total++; if (xerr != 0) begin bad++; $display("FAIL settle0_x_seq got=%0d_errors exp=0", xerr); end
    total++; if (busy_cnt != 32) begin bad++; $display("FAIL settle0_busy_cnt got=%0d exp=32", busy_cnt); end
    total++; if (done_idx != 33) begin bad++; $display("FAIL settle0_done_idx got=%0d exp=33", done_idx); end
    total++; if (sigv !== model(32)) begin bad++; $display("FAIL settle0_sig got=%h exp=%h", sigv, model(32)); end
  endtask

`ifdef AIG_SWEEP_CAPTURE_EN
  task automatic test_capture();
    rd_addr_a = 5'd7;
    tick();
    total++; if (rd_data_a !== 10'd7) begin bad++; $display("FAIL capture_rd7 got=%0d exp=7", rd_data_a); end
    rd_addr_a = 5'd31;
    tick();
    total++; if (rd_data_a !== 10'd31) begin bad++; $display("FAIL capture_rd31 got=%0d exp=31", rd_data_a); end
  endtask
`endif

  task automatic test_reset_mid();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy_a); end
    total++; if (x_a !== 5'd0) begin bad++; $display("FAIL rstmid_x got=%h exp=00", x_a); end
    total++; if (sig_a !== 16'hFFFF) begin bad++; $display("FAIL rstmid_sig got=%h exp=ffff", sig_a); end
    total++; if (pass_a !== 1'b0) begin bad++; $display("FAIL rstmid_pass got=%b exp=0", pass_a); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin bad++; $display("FAIL rstmid_quiet got=%b%b exp=00", done_a, busy_a); end
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    {start_a, abort_a, start_b, abort_b, start_c, abort_c} = '0;
    exp_a = '0;
    exp_b = '0;
    exp_c = '0;
`ifdef AIG_SWEEP_CAPTURE_EN
    rd_addr_a = '0;
    rd_addr_b = '0;
    rd_addr_c = '0;
`endif
    #1;
    test_reset();
    test_timing();
    test_loopback();
    test_start_ignored();
    test_abort();
`ifdef AIG_SWEEP_CAPTURE_EN
    test_capture();
`endif
    test_settle0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
